turn_scheduler: RTL and testbench

- Sequences the four per-player game_logic instances: owns the time-sliced round-robin player pointer, per-player enables, finish detection, win pulse and finish ordering.
- Replaces ad-hoc rotation/win logic at game top; game_logic instances consume enables and win, and game top muxes position/status by current_player.
- Adds an explicit start/run/done lifecycle and a game-over indication.

---
 rtl/game_pkg.sv | 21 ++
 rtl/next_player_picker.sv | 31 +++
 rtl/turn_scheduler.sv | 172 +++++++++++++++++
 tb/tb_turn_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencing blocks.
package game_pkg;

    localparam int         NUM_PLAYERS_MAX   = 4;
    localparam int         STATUS_FINISH_BIT = 3;
    localparam logic [3:0] STATUS_NEUTRAL    = 4'b1000;

    typedef logic [1:0] player_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A code with the finish bit set counts as finished, except the neutral code.
    function automatic logic is_finished(input logic [3:0] code);
        return code[STATUS_FINISH_BIT] && (code != STATUS_NEUTRAL);
    endfunction

endpackage

// File: rtl/next_player_picker.sv
// Rotating-priority search: first set bit of mask at or after base, wrapping within N players.
module next_player_picker
    import game_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [NUM_PLAYERS_MAX-1:0] mask,
    input  player_idx_t                base,
    output logic                       found,
    output player_idx_t                idx
);

    logic [2:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, base} + 3'(k);
            if (pos >= 3'(N)) begin
                pos = pos - 3'(N);
            end
            if (!found && mask[pos[1:0]]) begin
                found = 1'b1;
                idx   = pos[1:0];
            end
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Round-robin turn slicing, finish detection and finish ordering for up to four players.
// Define TURN_SKIP_EN to make slice advances skip players that are no longer enabled.
module turn_scheduler
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS  = 4,
    parameter int SLICE_CYCLES = 100,
    parameter int FINISH_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [4*NUM_PLAYERS-1:0] status_codes,
    output logic [1:0]               current_player,
    output logic                     slice_tick,
    output logic [NUM_PLAYERS-1:0]   enables,
    output logic                     win,
    output logic [1:0]               winner,
    output logic [7:0]               finish_order,
    output logic [2:0]               finish_count,
    output logic                     game_over
);

    localparam int                     CNT_W       = ($clog2(SLICE_CYCLES) > 1) ? $clog2(SLICE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST    = CNT_W'(SLICE_CYCLES - 1);
    localparam logic [NUM_PLAYERS-1:0] EN_ALL      = '1;
    localparam player_idx_t            LAST_PLAYER = player_idx_t'(NUM_PLAYERS - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    player_idx_t              cur_q, cur_d;
    logic                     tick_q, tick_d;
    logic [NUM_PLAYERS-1:0]   en_q, en_d;
    logic                     win_q, win_d;
    player_idx_t              winner_q, winner_d;
    logic [7:0]               order_q, order_d;
    logic [2:0]               fcnt_q, fcnt_d;
    logic                     over_q, over_d;

    logic [NUM_PLAYERS_MAX-1:0] fin_mask;
    logic [NUM_PLAYERS_MAX-1:0] en_after;
    logic                       fin_found;
    player_idx_t                fin_idx;
    player_idx_t                base_next;
    player_idx_t                adv_player;

    always_comb begin
        fin_mask = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            fin_mask[i] = en_q[i] && is_finished(status_codes[4*i +: 4]);
        end
    end

    next_player_picker #(.N(NUM_PLAYERS)) u_fin_pick (
        .mask  (fin_mask),
        .base  (2'd0),
        .found (fin_found),
        .idx   (fin_idx)
    );

    // Rotation must already see the player finishing on this edge as gone.
    always_comb begin
        en_after = NUM_PLAYERS_MAX'(en_q);
        if (fin_found) begin
            en_after[fin_idx] = 1'b0;
        end
    end

    assign base_next = (cur_q == LAST_PLAYER) ? 2'd0 : cur_q + 2'd1;

`ifdef TURN_SKIP_EN
    logic        adv_found;
    player_idx_t adv_idx;

    next_player_picker #(.N(NUM_PLAYERS)) u_adv_pick (
        .mask  (en_after),
        .base  (base_next),
        .found (adv_found),
        .idx   (adv_idx)
    );

    assign adv_player = adv_found ? adv_idx : cur_q;
`else
    assign adv_player = base_next;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        tick_d   = 1'b0;
        en_d     = en_q;
        win_d    = 1'b0;
        winner_d = winner_q;
        order_d  = order_q;
        fcnt_d   = fcnt_q;
        over_d   = over_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    en_d     = EN_ALL;
                    cnt_d    = '0;
                    cur_d    = '0;
                    order_d  = '0;
                    fcnt_d   = '0;
                    winner_d = '0;
                    over_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if ((fcnt_q >= 3'(FINISH_LIMIT)) || (en_q == '0)) begin
                    state_d = ST_DONE;
                    over_d  = 1'b1;
                    en_d    = '0;
                end else begin
                    if (fin_found) begin
                        en_d                              = en_after[NUM_PLAYERS-1:0];
                        winner_d                          = fin_idx;
                        order_d[{fcnt_q[1:0], 1'b0} +: 2] = fin_idx;
                        fcnt_d                            = fcnt_q + 3'd1;
                        win_d                             = 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        cur_d  = adv_player;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cur_q    <= '0;
            tick_q   <= 1'b0;
            en_q     <= '0;
            win_q    <= 1'b0;
            winner_q <= '0;
            order_q  <= '0;
            fcnt_q   <= '0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            tick_q   <= tick_d;
            en_q     <= en_d;
            win_q    <= win_d;
            winner_q <= winner_d;
            order_q  <= order_d;
            fcnt_q   <= fcnt_d;
            over_q   <= over_d;
        end
    end

    assign current_player = cur_q;
    assign slice_tick     = tick_q;
    assign enables        = en_q;
    assign win            = win_q;
    assign winner         = winner_q;
    assign finish_order   = order_q;
    assign finish_count   = fcnt_q;
    assign game_over      = over_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed and randomized bench for turn_scheduler against a cycle-level game model.
module tb_turn_scheduler;

    localparam int NP = 4;
    localparam int SC = 4;
    localparam int FL = 4;

    logic            clk;
    logic            rst;
    logic            start;
    logic [4*NP-1:0] status_codes;
    logic [1:0]      current_player;
    logic            slice_tick;
    logic [NP-1:0]   enables;
    logic            win;
    logic [1:0]      winner;
    logic [7:0]      finish_order;
    logic [2:0]      finish_count;
    logic            game_over;

    turn_scheduler #(
        .NUM_PLAYERS  (NP),
        .SLICE_CYCLES (SC),
        .FINISH_LIMIT (FL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .status_codes   (status_codes),
        .current_player (current_player),
        .slice_tick     (slice_tick),
        .enables        (enables),
        .win            (win),
        .winner         (winner),
        .finish_order   (finish_order),
        .finish_count   (finish_count),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Game model: phase 0 idle, 1 running, 2 done.
    int       m_phase;
    int       m_cnt;
    int       m_cur;
    int       m_winner;
    int       m_fcnt;
    bit       m_en[NP];
    int       m_order[4];
    bit       m_win;
    bit       m_tick;
    bit       m_over;
    logic [3:0] st[NP];

    function automatic bit code_finished(input logic [3:0] c);
        return (c >= 4'd8) && (c != 4'd8);
    endfunction

    function automatic logic [3:0] rand_code();
        logic [3:0] c;
        if ($urandom_range(0, 1) == 0) c = 4'b1000;
        else c = 4'($urandom_range(0, 15));
        return c;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_cur = 0; m_winner = 0; m_fcnt = 0;
        m_win = 0; m_tick = 0; m_over = 0;
        for (int i = 0; i < NP; i++) m_en[i] = 0;
        for (int k = 0; k < 4; k++) m_order[k] = 0;
    endtask

    function automatic int next_turn(input int cur);
`ifdef TURN_SKIP_EN
        for (int d = 1; d <= NP; d++) begin
            if (m_en[(cur + d) % NP]) return (cur + d) % NP;
        end
        return cur;
`else
        return (cur + 1) % NP;
`endif
    endfunction

    task automatic model_step(input bit s);
        int  who;
        bit  any_en;
        m_win  = 0;
        m_tick = 0;
        if (m_phase != 1) begin
            if (s) begin
                m_phase = 1; m_cnt = 0; m_cur = 0; m_fcnt = 0; m_winner = 0; m_over = 0;
                for (int i = 0; i < NP; i++) m_en[i] = 1;
                for (int k = 0; k < 4; k++) m_order[k] = 0;
            end
        end else begin
            any_en = 0;
            for (int i = 0; i < NP; i++) if (m_en[i]) any_en = 1;
            if (m_fcnt >= FL || !any_en) begin
                m_phase = 2;
                m_over  = 1;
                for (int i = 0; i < NP; i++) m_en[i] = 0;
            end else begin
                who = -1;
                for (int i = NP - 1; i >= 0; i--) begin
                    if (m_en[i] && code_finished(st[i])) who = i;
                end
                if (who >= 0) begin
                    m_en[who]       = 0;
                    m_winner        = who;
                    m_order[m_fcnt] = who;
                    m_fcnt++;
                    m_win = 1;
                end
                m_cnt++;
                if (m_cnt == SC) begin
                    m_cnt  = 0;
                    m_tick = 1;
                    m_cur  = next_turn(m_cur);
                end
            end
        end
    endtask

    task automatic compare_all();
        int e;
        int o;
        e = 0;
        o = 0;
        for (int i = 0; i < NP; i++) if (m_en[i]) e |= (1 << i);
        for (int k = 0; k < 4; k++) o |= (m_order[k] << (2 * k));
        check_eq("current_player", current_player, m_cur);
        check_eq("slice_tick",     slice_tick,     m_tick);
        check_eq("enables",        enables,        e);
        check_eq("win",            win,            m_win);
        check_eq("winner",         winner,         m_winner);
        check_eq("finish_order",   finish_order,   o);
        check_eq("finish_count",   finish_count,   m_fcnt);
        check_eq("game_over",      game_over,      m_over);
    endtask

    // Inputs change just after a falling edge; outputs are checked on the next falling edge.
    task automatic step(input bit s);
        start = s;
        for (int i = 0; i < NP; i++) status_codes[4*i +: 4] = st[i];
        @(posedge clk);
        model_step(s);
        @(negedge clk);
        compare_all();
        start = 1'b0;
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NP; i++) st[i] = 4'b1000;
        status_codes = '0;
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Idle without start, noise on the status inputs.
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < NP; i++) st[i] = rand_code();
            step(1'b0);
        end

        // Full rotation with neutral statuses.
        for (int i = 0; i < NP; i++) st[i] = 4'b1000;
        step(1'b1);
        for (int c = 0; c < 20; c++) step(1'b0);

        // Single finish, then a persistent status must not re-trigger.
        st[2] = 4'b1010;
        for (int c = 0; c < 10; c++) step(1'b0);

        // Two simultaneous finishes are taken on consecutive cycles.
        st[1] = 4'b1010;
        st[3] = 4'b1111;
        for (int c = 0; c < 10; c++) step(1'b0);
        check_eq("order_after_three", finish_order, 8'b00_11_01_10);
        check_eq("count_after_three", finish_count, 3);

        // Start while running is ignored.
        step(1'b1);

        // Fourth finish ends the game.
        st[0] = 4'b1001;
        for (int c = 0; c < 6; c++) step(1'b0);
        check_eq("over_after_four", game_over, 1);
        check_eq("enables_after_four", enables, 0);

        // Restart and leave players 0 and 2 in rotation.
        for (int i = 0; i < NP; i++) st[i] = 4'b1000;
        step(1'b1);
        check_eq("count_after_restart", finish_count, 0);
        st[1] = 4'b1100;
        st[3] = 4'b1011;
        for (int c = 0; c < 24; c++) step(1'b0);
        mid_reset();
        for (int c = 0; c < 4; c++) step(1'b0);

        // Randomized games with occasional stray starts and resets.
        for (int g = 0; g < 14; g++) begin
            for (int i = 0; i < NP; i++) st[i] = ($urandom_range(0, 3) == 0) ? rand_code() : 4'b1000;
            step(1'b1);
            for (int c = 0; c < 120; c++) begin
                for (int i = 0; i < NP; i++) begin
                    if ($urandom_range(0, 19) == 0) st[i] = rand_code();
                end
                step($urandom_range(0, 15) == 0);
                if (c == 60 && (g % 5) == 2) mid_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
